// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and
// the start-bit midpoint derivation used by both TX and RX.
`timescale 1ns/1ps
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      CLEANUP = 3'd4
   } rx_state_t;

   // 25 MHz / 115200 baud
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;

   function automatic int unsigned half_bit(input int unsigned clks_per_bit);
      return (clks_per_bit - 1) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-in / byte-out bundle between the UART receiver and its consumers.
`timescale 1ns/1ps
interface uart_rx_if;
   logic       i_RX_Serial;
   logic       o_RX_DV;
   logic [7:0] o_RX_Byte;
   logic       o_RX_Frame_Err;
   logic       o_RX_Busy;

   modport slave (
      input  i_RX_Serial,
      output o_RX_DV,
      output o_RX_Byte,
      output o_RX_Frame_Err,
      output o_RX_Busy
   );

   modport master (
      output i_RX_Serial,
      input  o_RX_DV,
      input  o_RX_Byte,
      input  o_RX_Frame_Err,
      input  o_RX_Busy
   );
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; both stages reset to
// RESET_VALUE so an idle-high line does not look like activity after reset.
`timescale 1ns/1ps
module uart_sync_2ff #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VALUE;
         q    <= RESET_VALUE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit midpoint qualification, mid-bit data sampling,
// one-cycle byte valid / framing-error strobes, and break hold-off in CLEANUP.
`timescale 1ns/1ps
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input logic     i_Clock,
   input logic     i_Reset,
   uart_rx_if.slave rx
);
   localparam logic [15:0] HALF_BIT = 16'(half_bit(CLKS_PER_BIT));
   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

   rx_state_t   state, state_next;
   logic        rx_s;
   logic [15:0] cnt;
   logic [2:0]  idx;
   logic [7:0]  shift;
   logic [7:0]  rx_byte;
   logic        dv, frame_err;
   logic        bit_tick, mid_start, dv_set, err_set, busy;

   uart_sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
      .clk (i_Clock),
      .rst (i_Reset),
      .d   (rx.i_RX_Serial),
      .q   (rx_s)
   );

   assign bit_tick  = (cnt == LAST_CNT);
   assign mid_start = (cnt == HALF_BIT);

   always_ff @(posedge i_Clock) begin
      if (i_Reset) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (!rx_s)     state_next = START;
         START:   if (mid_start) state_next = rx_s ? IDLE : DATA;
         DATA:    if (bit_tick && idx == 3'd7) state_next = STOP;
         STOP:    if (bit_tick)  state_next = CLEANUP;
         CLEANUP: if (rx_s)      state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state != IDLE);
      dv_set  = (state == STOP) && bit_tick && rx_s;
      err_set = (state == STOP) && bit_tick && !rx_s;
   end

   // Datapath: counter, bit index, shift register and registered strobes
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         cnt       <= '0;
         idx       <= '0;
         shift     <= '0;
         rx_byte   <= '0;
         dv        <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         dv        <= dv_set;
         frame_err <= err_set;
         if (dv_set) rx_byte <= shift;
         unique case (state)
            START: begin
               if (mid_start) begin
                  cnt <= '0;
                  idx <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  shift[idx] <= rx_s;
                  cnt        <= '0;
                  if (idx != 3'd7) idx <= idx + 3'd1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            STOP:    cnt <= bit_tick ? 16'd0 : cnt + 16'd1;
            default: cnt <= '0;
         endcase
      end
   end

   assign rx.o_RX_DV        = dv;
   assign rx.o_RX_Byte      = rx_byte;
   assign rx.o_RX_Frame_Err = frame_err;
   assign rx.o_RX_Busy      = busy;
endmodule
